// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit:
// widths, forwarding select codes, FSM encoding and scoreboard slot layout.
package forwarding_hazard_unit_pkg;

  localparam int BITS_REGS          = 5;
  localparam int BITS_CORTOCIRCUITO = 3;
  localparam int BITS_COUNT         = 32;

  // Forwarding select codes seen by the EX operand muxes; 3'b011..3'b111 unused.
  localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_REG   = 3'b000;
  localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_EXMEM = 3'b001;
  localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_MEMWB = 3'b010;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LD_STALL = 1'b1
  } state_t;

  // One scoreboard slot shadows one pipeline stage's destination.
  typedef struct packed {
    logic                 valid;
    logic [BITS_REGS-1:0] dest;
    logic                 regwrite;
    logic                 memread;
  } slot_t;

  localparam int    SLOT_W     = $bits(slot_t);
  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage instruction fields into the hazard unit and the select/stall
// controls back out to the pipeline.
//
// Handshake: the ID fields are meaningful only while i_id_valid=1. The unit
// accepts the ID instruction on a rising edge when i_id_valid=1 and
// o_pc_write=1 (its "ready"); while o_pc_write=0 the pipeline must hold the
// same ID fields stable so they are re-evaluated next cycle. i_flush squashes
// the ID instruction regardless of o_pc_write.
interface forwarding_hazard_unit_if;
  import forwarding_hazard_unit_pkg::*;

  logic                          i_id_valid;
  logic [BITS_REGS-1:0]          i_id_rs;
  logic [BITS_REGS-1:0]          i_id_rt;
  logic                          i_id_use_rs;
  logic                          i_id_use_rt;
  logic [BITS_REGS-1:0]          i_id_dest;
  logic                          i_id_regwrite;
  logic                          i_id_memread;
  logic                          i_flush;

  logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A;
  logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B;
  logic                          o_pc_write;
  logic                          o_ifid_write;
  logic                          o_idex_bubble;
  logic [BITS_COUNT-1:0]         o_stall_count;

  // Debug visibility of the FSM and the oldest scoreboard slot.
  state_t                        o_state;
  slot_t                         o_wb_slot;

  modport master (
    output i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_id_dest, i_id_regwrite, i_id_memread, i_flush,
    input  o_corto_register_A, o_corto_register_B, o_pc_write,
           o_ifid_write, o_idex_bubble, o_stall_count, o_state, o_wb_slot
  );

  modport slave (
    input  i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_id_dest, i_id_regwrite, i_id_memread, i_flush,
    output o_corto_register_A, o_corto_register_B, o_pc_write,
           o_ifid_write, o_idex_bubble, o_stall_count, o_state, o_wb_slot
  );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Combinational forwarding select for one source register. The youngest
// producer (EX slot) wins over the MEM slot; WB producers are served by the
// write-first register file, so they map to FWD_REG.
module fwd_select
  import forwarding_hazard_unit_pkg::*;
(
  input  logic                          en,
  input  logic [BITS_REGS-1:0]          r,
  input  logic                          ex_valid,
  input  logic                          ex_regwrite,
  input  logic [BITS_REGS-1:0]          ex_dest,
  input  logic                          mem_valid,
  input  logic                          mem_regwrite,
  input  logic [BITS_REGS-1:0]          mem_dest,
  output logic                          ex_hit,
  output logic [BITS_CORTOCIRCUITO-1:0] code
);

  logic mem_hit;
  logic r_nonzero;

  // r0 is hardwired zero and never forwarded.
  assign r_nonzero = (r != '0);
  assign ex_hit    = ex_valid  & ex_regwrite  & (ex_dest  == r) & r_nonzero;
  assign mem_hit   = mem_valid & mem_regwrite & (mem_dest == r) & r_nonzero;

  // Priority select: EX producer, then MEM producer, else register file.
  always_comb begin
    code = FWD_REG;
    if (en) begin
      if (ex_hit)       code = FWD_EXMEM;
      else if (mem_hit) code = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// ID-stage hazard unit: shadows EX/MEM/WB destinations in a 3-slot
// scoreboard, registers forwarding selects so they reach EX together with the
// ID/EX register, and stalls one cycle on a load-use dependency.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  forwarding_hazard_unit_if.slave  bus
);

  slot_t                         ex_q;
  slot_t                         mem_q;
  slot_t                         wb_q;
  state_t                        state_q;
  logic [BITS_CORTOCIRCUITO-1:0] code_a_q;
  logic [BITS_CORTOCIRCUITO-1:0] code_b_q;
  logic [BITS_COUNT-1:0]         stall_count_q;

  logic                          hit_a;
  logic                          hit_b;
  logic [BITS_CORTOCIRCUITO-1:0] code_a;
  logic [BITS_CORTOCIRCUITO-1:0] code_b;
  logic                          stall;
  logic                          issue;

  fwd_select u_sel_a (
    .en           (bus.i_id_valid & bus.i_id_use_rs),
    .r            (bus.i_id_rs),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_dest      (ex_q.dest),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_dest     (mem_q.dest),
    .ex_hit       (hit_a),
    .code         (code_a)
  );

  fwd_select u_sel_b (
    .en           (bus.i_id_valid & bus.i_id_use_rt),
    .r            (bus.i_id_rt),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_dest      (ex_q.dest),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_dest     (mem_q.dest),
    .ex_hit       (hit_b),
    .code         (code_b)
  );

  // A load in EX cannot forward yet; the consumer waits one cycle. Flush wins.
  assign stall = bus.i_id_valid & ~bus.i_flush & ex_q.memread &
                 ((hit_a & bus.i_id_use_rs) | (hit_b & bus.i_id_use_rt));
  assign issue = bus.i_id_valid & ~stall & ~bus.i_flush;

  assign bus.o_pc_write         = ~stall;
  assign bus.o_ifid_write       = ~stall;
  assign bus.o_idex_bubble      = stall | bus.i_flush;
  assign bus.o_corto_register_A = code_a_q;
  assign bus.o_corto_register_B = code_b_q;
  assign bus.o_stall_count      = stall_count_q;
  assign bus.o_state            = state_q;
  assign bus.o_wb_slot          = wb_q;

  // Scoreboard shift, registered selects, stall counter and stall FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q          <= SLOT_EMPTY;
      mem_q         <= SLOT_EMPTY;
      wb_q          <= SLOT_EMPTY;
      state_q       <= ST_RUN;
      code_a_q      <= FWD_REG;
      code_b_q      <= FWD_REG;
      stall_count_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue) begin
        ex_q <= '{valid:    1'b1,
                  dest:     bus.i_id_dest,
                  regwrite: bus.i_id_regwrite,
                  memread:  bus.i_id_memread};
      end else begin
        ex_q <= SLOT_EMPTY;
      end

      // A bubble entering EX must read the register file.
      code_a_q <= issue ? code_a : FWD_REG;
      code_b_q <= issue ? code_b : FWD_REG;

      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end

      case (state_q)
        ST_RUN:      state_q <= stall ? ST_LD_STALL : ST_RUN;
        ST_LD_STALL: state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

endmodule
